counterup16_1clk_negedge_sync_resetn: RTL

COUNTERUP16_1CLK_NEGEDGE_SYNC_RESETN -- requirements
Module: counterup16_1clk_negedge_sync_resetn

---
 rtl/counterup16_pkg.sv | 9 +
 rtl/counterup16_prescaler.sv | 34 +++
 rtl/counterup16_1clk_negedge_sync_resetn.sv | 87 ++++++++
 3 files changed

// File: rtl/counterup16_pkg.sv
// Shared widths and constants for the 16-bit falling-edge up counter.
package counterup16_pkg;

  localparam int unsigned CNT_WIDTH        = 16;
  localparam logic [CNT_WIDTH-1:0] COUNT_RESET = 16'h0000;
  localparam int unsigned PRESCALE_DIV_MAX = 256;
  localparam int unsigned PHASE_WIDTH      = $clog2(PRESCALE_DIV_MAX);

endpackage

// File: rtl/counterup16_prescaler.sv
// Step prescaler: emits one tick every PRESCALE_DIV enabled cycles.
// Used only when COUNTERUP16_PRESCALE_EN is defined.
module counterup16_prescaler
  import counterup16_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic clock0,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam logic [PHASE_WIDTH-1:0] LAST_PHASE = PHASE_WIDTH'(PRESCALE_DIV - 1);

  logic [PHASE_WIDTH-1:0] r_phase;
  logic                   w_last;

  assign w_last = (r_phase == LAST_PHASE);
  assign tick   = enable & w_last;

  // Phase holds while disabled; restart (load) realigns to a full period.
  always_ff @(negedge clock0) begin
    if (!reset) begin
      r_phase <= '0;
    end else if (restart) begin
      r_phase <= '0;
    end else if (enable) begin
      r_phase <= w_last ? '0 : r_phase + PHASE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/counterup16_1clk_negedge_sync_resetn.sv
// 16-bit up counter on the falling edge with load, terminal wrap/saturate and
// sticky overflow. Define COUNTERUP16_PRESCALE_EN to divide steps by PRESCALE_DIV.
module counterup16_1clk_negedge_sync_resetn
  import counterup16_pkg::*;
#(
  parameter int unsigned PRESCALE_DIV = 4
) (
  input  logic                 clock0,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_value,
  input  logic [CNT_WIDTH-1:0] terminal,
  input  logic                 saturate,
  input  logic                 clear_ovf,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 tc,
  output logic                 ovf
);

  if (PRESCALE_DIV < 1 || PRESCALE_DIV > PRESCALE_DIV_MAX) begin : g_bad_div
    $error("PRESCALE_DIV must lie in 1..256");
  end

  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_tc;
  logic                 r_ovf;
  logic                 w_tick;
  logic                 w_step;
  logic                 w_at_term;

`ifdef COUNTERUP16_PRESCALE_EN
  counterup16_prescaler #(
    .PRESCALE_DIV (PRESCALE_DIV)
  ) u_prescaler (
    .clock0  (clock0),
    .reset   (reset),
    .enable  (enable),
    .restart (load),
    .tick    (w_tick)
  );
`else
  assign w_tick = 1'b1;
`endif

  assign w_step    = enable & w_tick;
  assign w_at_term = (r_count == terminal);

  // Priority: reset > load > step > hold.
  always_ff @(negedge clock0) begin
    if (!reset) begin
      r_count <= COUNT_RESET;
      r_tc    <= 1'b0;
    end else if (load) begin
      r_count <= load_value;
      r_tc    <= 1'b0;
    end else if (w_step) begin
      if (w_at_term) begin
        r_tc <= 1'b1;
        if (!saturate) begin
          r_count <= COUNT_RESET;
        end
      end else begin
        r_count <= r_count + CNT_WIDTH'(1);
        r_tc    <= 1'b0;
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  // A set event wins over a simultaneous clear.
  always_ff @(negedge clock0) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (!load && w_step && w_at_term) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign ovf   = r_ovf;

endmodule
